// File: rtl/stack_upstream_rx.sv
// Upstream receive port: accepts manager beats, buffers them in a FIFO with a registered head,
// and reports packet count. Define STU_RX_PROTOCOL_CHECK_EN to enable the SOM/MOM/EOM framing checker.
module stack_upstream_rx #(
  parameter int DATA_W = 64,
  parameter int OOB_W  = 32,
  parameter int TYPE_W = 2,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              mgr__stu__valid,
  input  logic [1:0]        mgr__stu__cntl,
  input  logic [TYPE_W-1:0] mgr__stu__type,
  input  logic [DATA_W-1:0] mgr__stu__data,
  input  logic [OOB_W-1:0]  mgr__stu__oob_data,
  output logic              stu__mgr__ready,
  output logic              stu__cns__valid,
  output logic [1:0]        stu__cns__cntl,
  output logic [TYPE_W-1:0] stu__cns__type,
  output logic [DATA_W-1:0] stu__cns__data,
  output logic [OOB_W-1:0]  stu__cns__oob_data,
  input  logic              cns__stu__ready,
  output logic [15:0]       stu__sys__pktCount,
  output logic              stu__sys__frameErr,
  output logic              stu__sys__empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 + TYPE_W + DATA_W + OOB_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] head_q, head_d, in_entry;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, remain;
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic             ready_q, accept, push, pop, out_valid;

  assign in_entry  = {mgr__stu__cntl, mgr__stu__type, mgr__stu__data, mgr__stu__oob_data};
  assign accept    = mgr__stu__valid & ready_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & cns__stu__ready;

`ifdef STU_RX_PROTOCOL_CHECK_EN
  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} frame_state_e;
  frame_state_e state_q, state_d;
  logic         frame_err_q, frame_err_d, write_en;

  always_comb begin
    state_d     = state_q;
    frame_err_d = 1'b0;
    write_en    = accept;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          unique case (mgr__stu__cntl)
            CNTL_SOM:     state_d = IN_PKT;
            CNTL_SOM_EOM: state_d = IDLE;
            default: begin
              // Continuation beat with no open packet: consume it but never store it.
              write_en    = 1'b0;
              frame_err_d = 1'b1;
            end
          endcase
        end
        IN_PKT: begin
          unique case (mgr__stu__cntl)
            CNTL_MOM:     state_d = IN_PKT;
            CNTL_EOM:     state_d = IDLE;
            CNTL_SOM:     frame_err_d = 1'b1;
            default: begin
              frame_err_d = 1'b1;
              state_d     = IDLE;
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q     <= IDLE;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign push               = write_en;
  assign stu__sys__frameErr = frame_err_q;
`else
  assign push               = accept;
  assign stu__sys__frameErr = 1'b0;
`endif

  always_comb begin
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    remain      = count_q - CNT_W'(pop);
    pkt_count_d = pkt_count_q + 16'(push & mgr__stu__cntl[1]);
    head_d      = head_q;
    // Refill the head when it is consumed or empty; bypass the incoming beat if nothing older is queued.
    if (pop || !out_valid) begin
      if (remain != '0) head_d = mem[rd_ptr_d];
      else if (push)    head_d = in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      head_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      head_q      <= head_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      // Two spare entries cover the beat the manager may launch before seeing ready fall.
      ready_q     <= (count_d <= CNT_W'(DEPTH - 2));
    end
  end

  assert property (@(posedge clk) disable iff (!reset_poweron) !(push && count_q == CNT_W'(DEPTH)));

  assign {stu__cns__cntl, stu__cns__type, stu__cns__data, stu__cns__oob_data} = head_q;
  assign stu__cns__valid    = out_valid;
  assign stu__sys__empty    = !out_valid;
  assign stu__mgr__ready    = ready_q;
  assign stu__sys__pktCount = pkt_count_q;
endmodule

// File: doc/stack_upstream_rx.md
# stack_upstream_rx

Receive end of the manager-to-stack upstream bus: accepts beats from the manager's `mgr__stu__*` port, applies back-pressure with `stu__mgr__ready`, checks SOM/MOM/EOM framing, and buffers beats in an 8-entry FIFO. Beats drain to the stack-side consumer over a valid/ready interface, and the block reports packet and framing status to the system. It sits in the stack logic, directly opposite each manager instance.

## Interface
- `DATA_W`, 64: width of `*__data`
- `OOB_W`, 32: width of `*__oob_data`
- `TYPE_W`, 2: width of `*__type` (control/data, vector/scalar)
- `DEPTH`, 8: FIFO entries (power of two, ≥4)
- `clk` in 1: clock
- `reset_poweron` in 1: reset; one clock, reset is asynchronous and active-low
- `mgr__stu__valid` in 1: upstream beat valid
- `mgr__stu__cntl` in 2: framing: 2'b01 SOM, 2'b00 MOM, 2'b10 EOM, 2'b11 SOM_EOM
- `mgr__stu__type` in TYPE_W: beat type
- `mgr__stu__data` in DATA_W: payload
- `mgr__stu__oob_data` in OOB_W: out-of-band data
- `stu__mgr__ready` out 1: registered ready to manager
- `stu__cns__valid` out 1: output beat valid
- `stu__cns__cntl`, `stu__cns__type`, `stu__cns__data`, `stu__cns__oob_data` out 2/TYPE_W/DATA_W/OOB_W: output beat fields
- `cns__stu__ready` in 1: consumer ready
- `stu__sys__pktCount` out 16: EOM/SOM_EOM beats accepted, wraps 0xFFFF→0
- `stu__sys__frameErr` out 1: one-cycle pulse on a framing violation
- `stu__sys__empty` out 1: FIFO empty

## Operation
- Input transfer: `mgr__stu__valid & stu__mgr__ready` on a rising edge. Output transfer: `stu__cns__valid & cns__stu__ready`.
- The FIFO stores {cntl, type, data, oob} per entry. Occupancy `count` is 0..DEPTH.
- Framing FSM with two states, IDLE and IN_PKT; reset state is IDLE.
  - IDLE + SOM → write beat, go to IN_PKT.
  - IDLE + SOM_EOM → write beat, stay in IDLE, increment pktCount.
  - IDLE + MOM or EOM → drop the beat (it is consumed, not written), pulse frameErr.
  - IN_PKT + MOM → write beat.
  - IN_PKT + EOM → write beat, go to IDLE, increment pktCount.
  - IN_PKT + SOM → pulse frameErr, write beat, stay in IN_PKT (the beat starts a new packet).
  - IN_PKT + SOM_EOM → pulse frameErr, write beat, go to IDLE, increment pktCount.
- Only accepted beats are checked. The FSM ignores type and data.
- Simultaneous input write and output read in one cycle leave `count` unchanged. Both pointers advance and wrap modulo DEPTH.

## Timing
- Reset values:
  - `stu__mgr__ready` = 0, rising to 1 on the first clock edge after reset deassertion.
  - `stu__cns__valid` = 0, `stu__sys__empty` = 1.
  - `stu__sys__pktCount` = 0, `stu__sys__frameErr` = 0.
  - Output data fields = 0.
- `stu__mgr__ready` is registered. It is next-cycle 1 iff `count_next ≤ DEPTH-2`. Two free entries absorb a beat already in flight, so no accepted beat is ever lost. A write while `count == DEPTH` is impossible and is asserted in simulation.
- Latency: a beat accepted at edge N appears on `stu__cns__*` after edge N (registered head), provided the FIFO was otherwise empty. Throughput is one beat per cycle in each direction.
- Output fields stay stable while `stu__cns__valid & !cns__stu__ready`.
- `stu__sys__frameErr` pulses high for the cycle after the offending edge. `stu__sys__pktCount` updates on the same edge as the EOM acceptance.
- Reset asserted mid-packet flushes the FIFO, returns the FSM to IDLE, and clears all outputs asynchronously. No partial packet survives.

## Configuration
- `STU_RX_PROTOCOL_CHECK_EN` defined: framing FSM as above; violating beats are dropped or flagged.
- `STU_RX_PROTOCOL_CHECK_EN` undefined:
  - FSM removed; every accepted beat is written unchanged.
  - `stu__sys__frameErr` tied 0.
  - `stu__sys__pktCount` still increments on every accepted EOM or SOM_EOM.

## Test plan
- Single packet SOM, MOM, MOM, EOM (data 0x1..0x4), consumer always ready → output beats 0x1..0x4 with the same cntl, one per cycle, starting one cycle after each acceptance; pktCount = 1.
- Consumer ready held 0 while 8 beats are offered → ready drops once count reaches 7; exactly 7 or 8 beats are stored, none lost. Release consumer → all beats drain in order; ready returns to 1.
- EOM in IDLE with data 0xDEAD → beat not output; frameErr pulses once; pktCount unchanged.
- SOM, MOM, SOM, EOM → frameErr pulses on the third beat; all 4 beats output; pktCount = 1.
- Preset pktCount to 0xFFFF via 65535 SOM_EOM beats, then send one more → pktCount = 0.
- Reset asserted after SOM, MOM with the FIFO holding 2 beats → valid = 0, empty = 1 immediately. After release, a MOM beat raises frameErr (FSM is in IDLE).
